// File: rtl/sgd_rd_req_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sgd_rd_req_gen_pkg
// Purpose  : Shared constants, read-tag values and FSM state encoding for
//            the SGD read-request issuer.
// Contents : MEM_RD_A_TAG / MEM_RD_B_TAG  ARID values for A and B reads
//            LINE_BYTES                   bytes per line / R beat
//            AXI_SIZE_64B, AXI_BURST_INCR fixed AR attributes
//            rd_req_state_e               request FSM states
//            min3()                       unsigned three-way minimum
// Revision : 1.0 - initial release
// ============================================================================
package sgd_rd_req_gen_pkg;

  localparam logic [4:0] MEM_RD_A_TAG   = 5'd1;
  localparam logic [4:0] MEM_RD_B_TAG   = 5'd2;
  localparam int         LINE_BYTES     = 64;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ_B     = 3'd1,
    ST_REQ_A     = 3'd2,
    ST_EPOCH_END = 3'd3,
    ST_DRAIN     = 3'd4
  } rd_req_state_e;

  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sgd_rd_req_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sgd_rd_req_gen_if
// Purpose  : AXI read-address channel plus the R-channel handshake pair that
//            the issuer watches to return credit.
// Ports    : master - drives AR payload/valid, observes ARREADY, RVALID, RREADY
//            slave  - the memory side (and R consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface sgd_rd_req_gen_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 5
) ();

  logic                  m_axi_ARVALID;
  logic                  m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0] m_axi_ARADDR;
  logic [7:0]            m_axi_ARLEN;
  logic [ID_WIDTH-1:0]   m_axi_ARID;
  logic [2:0]            m_axi_ARSIZE;
  logic [1:0]            m_axi_ARBURST;
  logic                  m_axi_RVALID;
  logic                  m_axi_RREADY;

  modport master (
    output m_axi_ARVALID, m_axi_ARADDR, m_axi_ARLEN, m_axi_ARID,
           m_axi_ARSIZE, m_axi_ARBURST,
    input  m_axi_ARREADY, m_axi_RVALID, m_axi_RREADY
  );

  modport slave (
    input  m_axi_ARVALID, m_axi_ARADDR, m_axi_ARLEN, m_axi_ARID,
           m_axi_ARSIZE, m_axi_ARBURST,
    output m_axi_ARREADY, m_axi_RVALID, m_axi_RREADY
  );

endinterface
`default_nettype wire

// File: rtl/sgd_rd_req_gen_credit.sv
`default_nettype none
// ============================================================================
// Module   : sgd_rd_req_gen_credit
// Purpose  : Up/down counter of requested-but-unreturned R beats.
// Ports    : clk, rst         clock, asynchronous active-high reset
//            inc_en, inc_len  add inc_len beats (AR handshake)
//            dec_en           remove one beat (R handshake)
//            req_len          candidate burst length for the room check
//            credit           current outstanding beat count
//            room             credit + req_len fits within MAX_OUTSTANDING
// Revision : 1.0 - initial release
// ============================================================================
module sgd_rd_req_gen_credit #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        inc_en,
  input  wire logic [31:0] inc_len,
  input  wire logic        dec_en,
  input  wire logic [31:0] req_len,
  output logic      [31:0] credit,
  output logic             room
);

  logic [31:0] credit_q;
  logic [31:0] credit_d;

  always_comb begin
    credit_d = credit_q;
    if (inc_en) begin
      credit_d = credit_d + inc_len;
    end
    if (dec_en) begin
      credit_d = credit_d - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= '0;
    end else begin
      // An R beat with nothing outstanding means the memory side is broken.
      assert (!(dec_en && (credit_q == 32'd0)));
      credit_q <= credit_d;
    end
  end

  // 33-bit compare so a large req_len cannot wrap into a false "fits".
  assign room   = ({1'b0, credit_q} + {1'b0, req_len}) <= 33'(MAX_OUTSTANDING);
  assign credit = credit_q;

endmodule
`default_nettype wire

// File: rtl/sgd_rd_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : sgd_rd_req_gen
// Purpose  : Issues AXI AR bursts for the SGD engine. Each epoch walks the B
//            (label) region and A (feature) region interleaved: one B line,
//            then that line's A lines, with A bursts split at 4 KB pages and
//            issue throttled by an outstanding-beat credit counter.
// Ports    : clk, rst                 clock, asynchronous active-high reset
//            started                  start pulse (IDLE only)
//            addr_a, addr_b           region bases, line aligned
//            num_b_lines              B lines per epoch
//            a_lines_per_b            A lines following each B line
//            num_epochs               epochs to run
//            m_axi                    AR channel + observed R handshake
//            done                     run complete, held until next start
//            state_counters_rd_req    cycles stalled with ARVALID & ~ARREADY
// Revision : 1.0 - initial release
// ============================================================================
module sgd_rd_req_gen
  import sgd_rd_req_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 5,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 64
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  started,
  input  wire logic [ADDR_WIDTH-1:0] addr_a,
  input  wire logic [ADDR_WIDTH-1:0] addr_b,
  input  wire logic [31:0]           num_b_lines,
  input  wire logic [31:0]           a_lines_per_b,
  input  wire logic [31:0]           num_epochs,
  sgd_rd_req_gen_if.master           m_axi,
  output logic                       done,
  output logic [31:0]                state_counters_rd_req
);

  localparam int BEAT_BYTES     = DATA_WIDTH / 8;
  localparam int LINE_SHIFT     = $clog2(BEAT_BYTES);
  localparam int LINES_PER_PAGE = 4096 / BEAT_BYTES;

  rd_req_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cfg_addr_a_q, cfg_addr_a_d;
  logic [ADDR_WIDTH-1:0] cfg_addr_b_q, cfg_addr_b_d;
  logic [31:0]           cfg_num_b_q, cfg_num_b_d;
  logic [31:0]           cfg_a_per_b_q, cfg_a_per_b_d;
  logic [31:0]           cfg_epochs_q, cfg_epochs_d;
  logic [ADDR_WIDTH-1:0] ptr_a_q, ptr_a_d;
  logic [ADDR_WIDTH-1:0] ptr_b_q, ptr_b_d;
  logic [31:0]           a_left_q, a_left_d;
  logic [31:0]           b_cnt_q, b_cnt_d;
  logic [31:0]           epoch_q, epoch_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic                  done_q, done_d;
  logic [31:0]           stall_q, stall_d;

  logic [31:0] page_room;
  logic [31:0] a_len;
  logic [31:0] req_len;
  logic [31:0] burst_len;
  logic        hs;
  logic        r_beat;
  logic [31:0] credit;
  logic        room;

  // Lines left before the next 4 KB boundary; always in 1..LINES_PER_PAGE.
  assign page_room = 32'(LINES_PER_PAGE) - 32'(ptr_a_q[11:LINE_SHIFT]);
  assign a_len     = min3(a_left_q, 32'(MAX_BURST), page_room);
  assign req_len   = (state_q == ST_REQ_B) ? 32'd1 : a_len;
  assign burst_len = {24'd0, arlen_q} + 32'd1;
  assign hs        = arvalid_q & m_axi.m_axi_ARREADY;
  assign r_beat    = m_axi.m_axi_RVALID & m_axi.m_axi_RREADY;

  sgd_rd_req_gen_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (hs),
    .inc_len (burst_len),
    .dec_en  (r_beat),
    .req_len (req_len),
    .credit  (credit),
    .room    (room)
  );

  always_comb begin
    state_d       = state_q;
    cfg_addr_a_d  = cfg_addr_a_q;
    cfg_addr_b_d  = cfg_addr_b_q;
    cfg_num_b_d   = cfg_num_b_q;
    cfg_a_per_b_d = cfg_a_per_b_q;
    cfg_epochs_d  = cfg_epochs_q;
    ptr_a_d       = ptr_a_q;
    ptr_b_d       = ptr_b_q;
    a_left_d      = a_left_q;
    b_cnt_d       = b_cnt_q;
    epoch_d       = epoch_q;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arid_d        = arid_q;
    done_d        = done_q;
    stall_d       = stall_q;

    if (arvalid_q && !m_axi.m_axi_ARREADY) begin
      stall_d = stall_q + 32'd1;
    end

    // Request slots: a new request is only loaded while ARVALID is low, so
    // a presented payload stays frozen until its handshake.
    case (state_q)
      ST_IDLE: begin
        if (started) begin
          cfg_addr_a_d  = addr_a;
          cfg_addr_b_d  = addr_b;
          cfg_num_b_d   = num_b_lines;
          cfg_a_per_b_d = a_lines_per_b;
          cfg_epochs_d  = num_epochs;
          ptr_a_d       = addr_a;
          ptr_b_d       = addr_b;
          b_cnt_d       = '0;
          epoch_d       = '0;
          done_d        = 1'b0;
          state_d       = ST_REQ_B;
        end
      end

      ST_REQ_B: begin
        if (arvalid_q) begin
          if (m_axi.m_axi_ARREADY) begin
            arvalid_d = 1'b0;
            ptr_b_d   = ptr_b_q + ADDR_WIDTH'(BEAT_BYTES);
            a_left_d  = cfg_a_per_b_q;
            b_cnt_d   = b_cnt_q + 32'd1;
            state_d   = ST_REQ_A;
          end
        end else if (room) begin
          arvalid_d = 1'b1;
          araddr_d  = ptr_b_q;
          arlen_d   = 8'd0;
          arid_d    = ID_WIDTH'(MEM_RD_B_TAG);
        end
      end

      ST_REQ_A: begin
        if (arvalid_q) begin
          if (m_axi.m_axi_ARREADY) begin
            arvalid_d = 1'b0;
            ptr_a_d   = ptr_a_q + (ADDR_WIDTH'(burst_len) << LINE_SHIFT);
            a_left_d  = a_left_q - burst_len;
            if (a_left_d == 32'd0) begin
              state_d = (b_cnt_q < cfg_num_b_q) ? ST_REQ_B : ST_EPOCH_END;
            end
          end
        end else if (room) begin
          arvalid_d = 1'b1;
          araddr_d  = ptr_a_q;
          arlen_d   = 8'(a_len - 32'd1);
          arid_d    = ID_WIDTH'(MEM_RD_A_TAG);
        end
      end

      ST_EPOCH_END: begin
        epoch_d = epoch_q + 32'd1;
        if (epoch_d < cfg_epochs_q) begin
          ptr_a_d = cfg_addr_a_q;
          ptr_b_d = cfg_addr_b_q;
          b_cnt_d = '0;
          state_d = ST_REQ_B;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (credit == 32'd0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cfg_addr_a_q  <= '0;
      cfg_addr_b_q  <= '0;
      cfg_num_b_q   <= '0;
      cfg_a_per_b_q <= '0;
      cfg_epochs_q  <= '0;
      ptr_a_q       <= '0;
      ptr_b_q       <= '0;
      a_left_q      <= '0;
      b_cnt_q       <= '0;
      epoch_q       <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arid_q        <= '0;
      done_q        <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      cfg_addr_a_q  <= cfg_addr_a_d;
      cfg_addr_b_q  <= cfg_addr_b_d;
      cfg_num_b_q   <= cfg_num_b_d;
      cfg_a_per_b_q <= cfg_a_per_b_d;
      cfg_epochs_q  <= cfg_epochs_d;
      ptr_a_q       <= ptr_a_d;
      ptr_b_q       <= ptr_b_d;
      a_left_q      <= a_left_d;
      b_cnt_q       <= b_cnt_d;
      epoch_q       <= epoch_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arid_q        <= arid_d;
      done_q        <= done_d;
      stall_q       <= stall_d;
    end
  end

  assign m_axi.m_axi_ARVALID = arvalid_q;
  assign m_axi.m_axi_ARADDR  = araddr_q;
  assign m_axi.m_axi_ARLEN   = arlen_q;
  assign m_axi.m_axi_ARID    = arid_q;
  assign m_axi.m_axi_ARSIZE  = AXI_SIZE_64B;
  assign m_axi.m_axi_ARBURST = AXI_BURST_INCR;
  assign done                  = done_q;
  assign state_counters_rd_req = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_sgd_rd_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sgd_rd_req_gen
// Purpose  : Self-checking bench for sgd_rd_req_gen. Expected AR bursts are
//            generated from the run configuration into a queue; observed AR
//            handshakes are queued by a monitor and compared in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sgd_rd_req_gen;
  import sgd_rd_req_gen_pkg::*;

  localparam int MAX_BURST       = 16;
  localparam int MAX_OUTSTANDING = 16;
  localparam int R_ALL           = 32'h7fff_ffff;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [4:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        started;
  logic [63:0] addr_a, addr_b;
  logic [31:0] num_b_lines, a_lines_per_b, num_epochs;
  logic        done;
  logic [31:0] stall_cnt;

  sgd_rd_req_gen_if #(.ADDR_WIDTH(64), .ID_WIDTH(5)) axi ();

  sgd_rd_req_gen #(
    .DATA_WIDTH      (512),
    .ID_WIDTH        (5),
    .ADDR_WIDTH      (64),
    .MAX_BURST       (MAX_BURST),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .started               (started),
    .addr_a                (addr_a),
    .addr_b                (addr_b),
    .num_b_lines           (num_b_lines),
    .a_lines_per_b         (a_lines_per_b),
    .num_epochs            (num_epochs),
    .m_axi                 (axi),
    .done                  (done),
    .state_counters_rd_req (stall_cnt)
  );

  always #5 clk = ~clk;

  ar_t exp_q[$];
  ar_t obs_q[$];
  int  issued   = 0;
  int  returned = 0;
  int  r_limit  = R_ALL;
  int  n_cmp    = 0;
  int  n_err    = 0;

  // Monitor: AR handshake happens at the posedge following this sample.
  always begin
    @(negedge clk);
    #3;
    if (axi.m_axi_ARVALID && axi.m_axi_ARREADY) begin
      obs_q.push_back({axi.m_axi_ARADDR, axi.m_axi_ARLEN, axi.m_axi_ARID,
                       axi.m_axi_ARSIZE, axi.m_axi_ARBURST});
      issued = issued + int'(axi.m_axi_ARLEN) + 1;
    end
  end

  // R responder: one beat per cycle for outstanding beats, up to r_limit.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      returned = issued;
      axi.m_axi_RVALID = 1'b0;
    end else if (returned < issued && returned < r_limit) begin
      axi.m_axi_RVALID = 1'b1;
      returned++;
    end else begin
      axi.m_axi_RVALID = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic gen_expected(input logic [63:0] pa0, input logic [63:0] pb0,
                              input int nb, input int na, input int ne);
    logic [63:0] pa, pb;
    int left, len, room;
    for (int e = 0; e < ne; e++) begin
      pa = pa0;
      pb = pb0;
      for (int b = 0; b < nb; b++) begin
        exp_q.push_back({pb, 8'd0, MEM_RD_B_TAG, AXI_SIZE_64B, AXI_BURST_INCR});
        pb = pb + 64;
        left = na;
        while (left > 0) begin
          room = 64 - int'((pa >> 6) & 64'h3f);
          len  = left;
          if (len > MAX_BURST) len = MAX_BURST;
          if (len > room) len = room;
          exp_q.push_back({pa, 8'(len - 1), MEM_RD_A_TAG, AXI_SIZE_64B, AXI_BURST_INCR});
          pa   = pa + 64'(len * 64);
          left = left - len;
        end
      end
    end
  endtask

  task automatic start_run(input logic [63:0] pa, input logic [63:0] pb,
                           input int nb, input int na, input int ne);
    addr_a = pa; addr_b = pb;
    num_b_lines = nb; a_lines_per_b = na; num_epochs = ne;
    started = 1'b1;
    gen_expected(pa, pb, nb, na, ne);
    step();
    started = 1'b0;
    // Scramble inputs: the run must use the latched copy.
    addr_a = 64'hdead_0000; addr_b = 64'hbeef_0000;
    num_b_lines = 7; a_lines_per_b = 9; num_epochs = 3;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && !done; i++) step();
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic compare_sb(input string tag);
    ar_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, "_missing_ar"}, 64'(obs_q.size()), 64'd1);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_addr"},  o.addr,         e.addr);
        chk({tag, "_len"},   64'(o.len),     64'(e.len));
        chk({tag, "_id"},    64'(o.id),      64'(e.id));
        chk({tag, "_size"},  64'(o.size),    64'(e.size));
        chk({tag, "_burst"}, 64'(o.burst),   64'(e.burst));
      end
    end
    chk({tag, "_extra_ar"}, 64'(obs_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] s_addr;
    logic [7:0]  s_len;
    logic [4:0]  s_id;
    logic [31:0] s_cnt;
    int          base;
    bit          stable;

    rst = 1'b1; started = 1'b0;
    addr_a = '0; addr_b = '0; num_b_lines = 1; a_lines_per_b = 1; num_epochs = 1;
    axi.m_axi_ARREADY = 1'b1; axi.m_axi_RREADY = 1'b1; axi.m_axi_RVALID = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    // Reset state
    chk("rst_arvalid", 64'(axi.m_axi_ARVALID), 64'd0);
    chk("rst_araddr",  axi.m_axi_ARADDR,       64'd0);
    chk("rst_arlen",   64'(axi.m_axi_ARLEN),   64'd0);
    chk("rst_arid",    64'(axi.m_axi_ARID),    64'd0);
    chk("rst_done",    64'(done),              64'd0);
    chk("rst_stall",   64'(stall_cnt),         64'd0);

    // Basic interleaved run
    start_run(64'h1000, 64'h8000, 2, 3, 1);
    chk("basic_done_cleared", 64'(done), 64'd0);
    wait_done("basic_done", 500);
    compare_sb("basic");
    step(3);
    chk("basic_done_held", 64'(done), 64'd1);

    // 4 KB split, plus a stray start pulse mid-run that must be ignored
    start_run(64'h1fc0, 64'h8000, 1, 5, 1);
    step(2);
    started = 1'b1; addr_a = 64'h0; addr_b = 64'h4000;
    step();
    started = 1'b0;
    wait_done("split_done", 500);
    compare_sb("split");

    // Two epochs; done must wait for every outstanding beat
    base = returned;
    r_limit = base;
    start_run(64'h3000, 64'h9000, 1, 1, 2);
    for (int i = 0; i < 200 && issued < base + 4; i++) step();
    chk("epochs_issued", 64'(issued - base), 64'd4);
    step(5);
    chk("epochs_done_before_drain", 64'(done), 64'd0);
    r_limit = R_ALL;
    wait_done("epochs_done", 500);
    compare_sb("epochs");

    // Credit limit with MAX_OUTSTANDING=16
    base = returned;
    r_limit = base;
    start_run(64'h1000, 64'ha000, 1, 40, 1);
    step(30);
    chk("credit_only_b",     64'(issued - base),        64'd1);
    chk("credit_arvalid_lo", 64'(axi.m_axi_ARVALID),    64'd0);
    r_limit = base + 1;
    step(30);
    chk("credit_first_a",    64'(issued - base),        64'd17);
    chk("credit_arvalid_lo2", 64'(axi.m_axi_ARVALID),   64'd0);
    r_limit = base + 16;
    step(30);
    chk("credit_one_short",  64'(issued - base),        64'd17);
    r_limit = base + 17;
    step(30);
    chk("credit_second_a",   64'(issued - base),        64'd33);
    r_limit = R_ALL;
    wait_done("credit_done", 1000);
    compare_sb("credit");

    // Backpressure: payload frozen, stall counter counts cycles
    axi.m_axi_ARREADY = 1'b0;
    start_run(64'h5000, 64'hc000, 1, 1, 1);
    for (int i = 0; i < 50 && !axi.m_axi_ARVALID; i++) step();
    chk("bp_arvalid", 64'(axi.m_axi_ARVALID), 64'd1);
    s_addr = axi.m_axi_ARADDR; s_len = axi.m_axi_ARLEN; s_id = axi.m_axi_ARID;
    s_cnt = stall_cnt;
    chk("bp_cnt_start", 64'(s_cnt), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!axi.m_axi_ARVALID || axi.m_axi_ARADDR !== s_addr ||
          axi.m_axi_ARLEN !== s_len || axi.m_axi_ARID !== s_id) stable = 1'b0;
    end
    chk("bp_payload_stable", 64'(stable), 64'd1);
    chk("bp_cnt_delta", 64'(stall_cnt - s_cnt), 64'd10);
    axi.m_axi_ARREADY = 1'b1;
    wait_done("bp_done", 500);
    compare_sb("bp");
    chk("bp_cnt_final", 64'(stall_cnt), 64'd10);

    // Reset abort while a request is pending
    axi.m_axi_ARREADY = 1'b0;
    start_run(64'h6000, 64'hd000, 2, 20, 1);
    exp_q.delete();
    for (int i = 0; i < 50 && !axi.m_axi_ARVALID; i++) step();
    chk("abort_arvalid_pre", 64'(axi.m_axi_ARVALID), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_arvalid_async", 64'(axi.m_axi_ARVALID), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    step(2);
    rst = 1'b0;
    axi.m_axi_ARREADY = 1'b1;
    step();
    chk("abort_no_ar", 64'(obs_q.size()), 64'd0);
    chk("abort_stall_cleared", 64'(stall_cnt), 64'd0);
    start_run(64'h6000, 64'hd000, 1, 2, 1);
    wait_done("restart_done", 500);
    compare_sb("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
